// File: rtl/serial_alu_seq_if.sv
// Controller-side bundle for serial_alu_seq: start/done handshake, operands and assembled result/flags.
interface serial_alu_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       cntrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, a, b, cntrl,
    input  busy, done, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  start, a, b, cntrl,
    output busy, done, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: drives one single-bit slice LSB first and assembles result + N/Z/V/C flags.
// Latency WIDTH+1 cycles from accepting start edge to done; start is ignored (not queued) while busy.
module serial_alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  serial_alu_seq_if.slave   bus,
  output logic              slice_a,
  output logic              slice_b,
  output logic              slice_cin,
  output logic              slice_zin,
  output logic [2:0]        slice_sel,
  input  logic              slice_out,
  input  logic              slice_cout,
  input  logic              slice_zout
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [2:0]       sel_lat;
  logic             carry_q;
  logic             zchain_q;
  logic [WIDTH-1:0] shift_q;

  logic             run;
  logic             is_arith;
  logic [WIDTH-1:0] shift_nxt;

  assign run       = (state == RUN);
  assign is_arith  = (sel_lat[2:1] == 2'b01);
  assign shift_nxt = {slice_out, shift_q[WIDTH-1:1]};

  // Slice inputs are quiet outside RUN so the slice sees all-zero while idle or in reset.
  always_comb begin
    slice_a   = run & a_lat[cnt];
    slice_b   = run & b_lat[cnt];
    slice_cin = run & carry_q;
    slice_zin = run & zchain_q;
    slice_sel = run ? sel_lat : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      a_lat         <= '0;
      b_lat         <= '0;
      sel_lat       <= 3'b000;
      carry_q       <= 1'b0;
      zchain_q      <= 1'b1;
      shift_q       <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.negative  <= 1'b0;
      bus.zero      <= 1'b1;
      bus.overflow  <= 1'b0;
      bus.carry_out <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_lat    <= bus.a;
            b_lat    <= bus.b;
            sel_lat  <= bus.cntrl;
            cnt      <= '0;
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            carry_q  <= bus.cntrl[0];
            zchain_q <= 1'b1;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          shift_q  <= shift_nxt;
          carry_q  <= slice_cout;
          zchain_q <= slice_zout;
          if (cnt == LAST) begin
            bus.result    <= shift_nxt;
            bus.negative  <= slice_out;
            bus.zero      <= slice_zout;
            // carry_q here is the carry into the MSB.
            bus.carry_out <= is_arith & slice_cout;
            bus.overflow  <= is_arith & (slice_cout ^ carry_q);
            bus.done      <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: behavioural slice model plus arithmetic reference model.
module tb_serial_alu_seq;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slice_a, slice_b, slice_cin, slice_zin;
  logic [2:0] slice_sel;
  logic slice_out, slice_cout, slice_zout;

  int checks = 0;
  int passed = 0;

  serial_alu_seq_if #(.WIDTH(W)) bus();

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_zin  (slice_zin),
    .slice_sel  (slice_sel),
    .slice_out  (slice_out),
    .slice_cout (slice_cout),
    .slice_zout (slice_zout)
  );

  always #5 clk = ~clk;

  // One-bit ALU slice as seen by the sequencer
  always_comb begin
    logic bb;
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    bb         = slice_b;
    case (slice_sel)
      3'b000: slice_out = slice_b;
      3'b010, 3'b011: begin
        if (slice_sel[0]) bb = ~slice_b;
        slice_out  = slice_a ^ bb ^ slice_cin;
        slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
      end
      3'b100: slice_out = slice_a & slice_b;
      3'b101: slice_out = slice_a | slice_b;
      3'b110: slice_out = slice_a ^ slice_b;
      default: slice_out = 1'b0;
    endcase
    slice_zout = slice_zin & ~slice_out;
  end

  // Reference: {result, negative, zero, overflow, carry_out}
  function automatic logic [W+3:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] c);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         v, co;
    r = '0; v = 1'b0; co = 1'b0; s = '0;
    case (c)
      3'd0: r = y;
      3'd2: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0]; co = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd3: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        r = s[W-1:0]; co = s[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd6: r = x ^ y;
      default: r = '0;
    endcase
    return {r, r[W-1], (r == '0), v, co};
  endfunction

  function automatic logic [W-1:0] rand64();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Pulses start for one cycle and returns the cycle index (1 = first after accept) where done is seen.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] c,
                        output int lat);
    lat = -1;
    bus.a = av; bus.b = bv; bus.cntrl = c; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom}; bus.cntrl = 3'($urandom);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cntrl = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 6'b000100)
      $display("FAIL reset_flags: got busy/done/n/z/v/c=%b want 000100",
               {bus.busy, bus.done, bus.negative, bus.zero, bus.overflow, bus.carry_out});
    else passed++;
    checks++;
    if (bus.result !== '0) $display("FAIL reset_result: got %h want 0", bus.result);
    else passed++;
    checks++;
    if ({slice_a, slice_b, slice_cin, slice_zin, slice_sel} !== 7'b0)
      $display("FAIL reset_slice: got %b want 0000000",
               {slice_a, slice_b, slice_cin, slice_zin, slice_sel});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic [2:0]   vc [5];
    logic [W+3:0] exp_v, got;
    int lat;
    va[0] = 64'h7FFF_FFFF_FFFF_FFFF; vb[0] = 64'h1;                   vc[0] = 3'b010;
    va[1] = 64'h5;                   vb[1] = 64'h5;                   vc[1] = 3'b011;
    va[2] = 64'h0;                   vb[2] = 64'h1;                   vc[2] = 3'b011;
    va[3] = 64'hF0F0_F0F0_F0F0_F0F0; vb[3] = 64'hFF00_FF00_FF00_FF00; vc[3] = 3'b110;
    va[4] = 64'hDEAD_BEEF_0000_0001; vb[4] = 64'h1234;                vc[4] = 3'b000;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], lat);
      checks++;
      if (lat !== W + 1) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W + 1);
      else passed++;
      exp_v = ref_op(va[i], vb[i], vc[i]);
      got   = {bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out};
      checks++;
      if (got !== exp_v) $display("FAIL dir%0d_result: got %h nzvc=%b want %h nzvc=%b",
                                  i, got[W+3:4], got[3:0], exp_v[W+3:4], exp_v[3:0]);
      else passed++;
    end
    // Spot-check the overflow vector against literal expectations too
    run_op(va[0], vb[0], vc[0], lat);
    checks++;
    if ({bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out} !==
        {64'h8000_0000_0000_0000, 4'b1010})
      $display("FAIL add_ovf_literal: got %h nzvc=%b want 8000000000000000 nzvc=1010",
               bus.result, {bus.negative, bus.zero, bus.overflow, bus.carry_out});
    else passed++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL idle_after_done: busy=%b want 0", bus.busy);
    else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    logic [2:0]   c;
    logic [W+3:0] exp_v, got;
    int lat;
    for (int i = 0; i < 24; i++) begin
      av = rand64(); bv = rand64(); c = 3'($urandom_range(0, 7));
      run_op(av, bv, c, lat);
      exp_v = ref_op(av, bv, c);
      got   = {bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out};
      checks++;
      if (lat !== W + 1 || got !== exp_v)
        $display("FAIL rand%0d op=%0d: got lat=%0d %h nzvc=%b want lat=%0d %h nzvc=%b",
                 i, c, lat, got[W+3:4], got[3:0], W + 1, exp_v[W+3:4], exp_v[3:0]);
      else passed++;
    end
  endtask

  task automatic test_restart();
    logic [W-1:0] a1, b1;
    logic [W+3:0] exp_v;
    int lat;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    exp_v = ref_op(a1, b1, 3'b010);
    lat = -1;
    bus.a = a1; bus.b = b1; bus.cntrl = 3'b010; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n == 10) begin
        bus.a = ~a1; bus.b = {$urandom, $urandom}; bus.cntrl = 3'b100; bus.start = 1'b1;
      end else if (n == W + 1) begin
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (n == 12) begin
        checks++;
        if ({slice_sel, slice_a, slice_b} !== {3'b010, a1[11], b1[11]})
          $display("FAIL restart_slice_drive: got sel/a/b=%b want %b",
                   {slice_sel, slice_a, slice_b}, {3'b010, a1[11], b1[11]});
        else passed++;
      end
      if (bus.done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== W + 1) $display("FAIL restart_latency: got %0d want %0d", lat, W + 1);
    else passed++;
    checks++;
    if ({bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out} !== exp_v)
      $display("FAIL restart_result: got %h want %h", bus.result, exp_v[W+3:4]);
    else passed++;
    // start was high during the DONE cycle only: it must not launch a new op
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL start_in_done_ignored: busy=%b want 0", bus.busy);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL start_in_done_ignored2: busy=%b want 0", bus.busy);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] av, bv;
    logic [W+3:0] exp_v;
    int dones;
    int lat;
    bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom}; bus.cntrl = 3'b010;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n < 30; n++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.zero, bus.negative, bus.overflow, bus.carry_out} !== 6'b001000 ||
        bus.result !== '0 || slice_sel !== 3'b000)
      $display("FAIL reset_mid_state: got busy/done/z/n/v/c=%b result=%h sel=%b want 001000 0 000",
               {bus.busy, bus.done, bus.zero, bus.negative, bus.overflow, bus.carry_out},
               bus.result, slice_sel);
    else passed++;
    dones = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) $display("FAIL reset_mid_no_done: got %0d done pulses want 0", dones);
    else passed++;
    @(posedge clk); #1;
    av = rand64(); bv = rand64();
    exp_v = ref_op(av, bv, 3'b011);
    run_op(av, bv, 3'b011, lat);
    checks++;
    if (lat !== W + 1 ||
        {bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out} !== exp_v)
      $display("FAIL after_reset_op: got lat=%0d %h want lat=%0d %h",
               lat, bus.result, W + 1, exp_v[W+3:4]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a2, b2;
    logic [W+3:0] exp_v;
    int first, second;
    first = -1; second = -1;
    a2 = rand64(); b2 = rand64();
    exp_v = ref_op(a2, b2, 3'b110);
    bus.a = rand64(); bus.b = rand64(); bus.cntrl = 3'b101; bus.start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 3 * W; n++) begin
      if (n == 1) begin
        bus.a = a2; bus.b = b2; bus.cntrl = 3'b110;
      end
      @(negedge clk);
      if (bus.done) begin
        if (first < 0) first = n;
        else begin
          second = n;
          bus.start = 1'b0;
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++;
    if (first !== W + 1 || second !== 2 * W + 3)
      $display("FAIL b2b_spacing: got done at %0d,%0d want %0d,%0d",
               first, second, W + 1, 2 * W + 3);
    else passed++;
    checks++;
    if ({bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out} !== exp_v)
      $display("FAIL b2b_second_result: got %h want %h", bus.result, exp_v[W+3:4]);
    else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_idle: busy=%b want 0", bus.busy);
    else passed++;
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cntrl = 3'b000;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
